// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-bank arbiter.
//   arb_state_t   : arbitration FSM states
//   mem_req_t     : one memory-port cycle (enable, write, address, data)
//   addr_in_range : true when an address maps to an implemented register
package i2c_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // 7-bit bus address the slave front-end answers to
    localparam logic [6:0] I2C_SLAVE_ADDR = 7'h42;

    // Read value for unimplemented register addresses
    localparam logic [DATA_W-1:0] OOR_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        CORE_RD_WAIT
    } arb_state_t;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a, input int depth);
        return int'({24'd0, a}) < depth;
    endfunction
endpackage

// File: rtl/i2c_wr_holding.sv
// Holding register for I2C slave writes.
//   wen/addr/wdata : write strobe and payload from the slave
//   clr            : arbiter has issued the held write this cycle
//   wr_pend        : a captured write is waiting for the memory port
//   hold_addr/data : captured write
//   wr_overrun     : sticky, a new write replaced one that was still pending
module i2c_wr_holding
    import i2c_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    output logic              wr_pend,
    output logic [ADDR_W-1:0] hold_addr,
    output logic [DATA_W-1:0] hold_data,
    output logic              wr_overrun
);
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_pend    <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
            wr_overrun <= 1'b0;
        end else if (wen) begin
            // A new strobe always wins over a clear in the same cycle so the
            // newest data is never lost; the write being issued now used the
            // old contents.
            hold_addr <= addr;
            hold_data <= wdata;
            wr_pend   <= 1'b1;
            if (wr_pend)
                wr_overrun <= 1'b1;
        end else if (clr) begin
            wr_pend <= 1'b0;
        end
    end
endmodule

// File: rtl/i2c_regbank_arbiter.sv
// Arbitrates one single-port byte register memory between the I2C slave
// application bus and a local core requester.
//   i2c_*    : slave write strobes, read-consumption pulses, prefetched i2c_rdata
//   core_*   : request/grant port, read data returned 2 cycles after grant
//   mem_*    : memory port, read data arrives the cycle after mem_en & !mem_we
//   wr_overrun : sticky I2C write overrun flag
module i2c_regbank_arbiter
    import i2c_pkg::*;
#(
    parameter int                MEM_DEPTH = 32,
    parameter logic [DATA_W-1:0] OOR_RDATA = OOR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2c_rw,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic              i2c_wen,
    input  logic [DATA_W-1:0] i2c_wdata,
    input  logic              i2c_rdata_used,
    output logic [DATA_W-1:0] i2c_rdata,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wr_overrun
);
    // Direction is informational only
    logic unused_rw;
    assign unused_rw = i2c_rw;

    logic              wr_pend, wr_clr;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;

    i2c_wr_holding u_hold (
        .clk        (clk),
        .rst        (rst),
        .wen        (i2c_wen),
        .addr       (i2c_addr),
        .wdata      (i2c_wdata),
        .clr        (wr_clr),
        .wr_pend    (wr_pend),
        .hold_addr  (hold_addr),
        .hold_data  (hold_data),
        .wr_overrun (wr_overrun)
    );

    arb_state_t        state, state_nxt;
    mem_req_t          mreq;
    logic              pf_pend, pf_oor, core_oor, pf_start;
    logic [ADDR_W-1:0] pf_addr, i2c_addr_q;
    logic              addr_chg, pf_hit, i2c_busy;

    assign addr_chg = (i2c_addr != i2c_addr_q);
    // Incoming I2C events this cycle also block the core, so an I2C write
    // that coincides with a core request is always serviced first.
    assign i2c_busy = wr_pend | pf_pend | i2c_wen | i2c_rdata_used | addr_chg;
    // Any real memory write to the prefetched address stales i2c_rdata
    assign pf_hit   = mreq.en & mreq.we & (mreq.addr == pf_addr);

    assign mem_en    = mreq.en;
    assign mem_we    = mreq.we;
    assign mem_addr  = mreq.addr;
    assign mem_wdata = mreq.wdata;

    always_comb begin
        state_nxt = state;
        mreq      = '0;
        wr_clr    = 1'b0;
        core_gnt  = 1'b0;
        pf_start  = 1'b0;
        case (state)
            IDLE: begin
                if (wr_pend)
                    state_nxt = WR;
                else if (pf_pend)
                    state_nxt = RD_ISSUE;
                else if (core_req && !i2c_busy) begin
                    core_gnt   = 1'b1;
                    mreq.en    = addr_in_range(core_addr, MEM_DEPTH);
                    mreq.we    = core_we;
                    mreq.addr  = core_addr;
                    mreq.wdata = core_wdata;
                    if (!core_we)
                        state_nxt = CORE_RD_WAIT;
                end
            end
            WR: begin
                wr_clr     = 1'b1;
                mreq.en    = addr_in_range(hold_addr, MEM_DEPTH);
                mreq.we    = 1'b1;
                mreq.addr  = hold_addr;
                mreq.wdata = hold_data;
                state_nxt  = IDLE;
            end
            RD_ISSUE: begin
                pf_start  = 1'b1;
                mreq.en   = addr_in_range(i2c_addr, MEM_DEPTH);
                mreq.addr = i2c_addr;
                state_nxt = RD_WAIT;
            end
            RD_WAIT:      state_nxt = IDLE;
            CORE_RD_WAIT: state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            pf_pend     <= 1'b1;
            pf_addr     <= '0;
            pf_oor      <= 1'b0;
            core_oor    <= 1'b0;
            i2c_addr_q  <= '0;
            i2c_rdata   <= '0;
            core_rdata  <= '0;
            core_rvalid <= 1'b0;
        end else begin
            state       <= state_nxt;
            i2c_addr_q  <= i2c_addr;
            core_rvalid <= 1'b0;
            // A trigger during the read re-arms pf_pend so the prefetch repeats
            if (i2c_rdata_used || addr_chg || pf_hit)
                pf_pend <= 1'b1;
            else if (pf_start)
                pf_pend <= 1'b0;
            if (pf_start) begin
                pf_addr <= i2c_addr;
                pf_oor  <= !addr_in_range(i2c_addr, MEM_DEPTH);
            end
            if (state == RD_WAIT)
                i2c_rdata <= pf_oor ? OOR_RDATA : mem_rdata;
            if (core_gnt && !core_we)
                core_oor <= !addr_in_range(core_addr, MEM_DEPTH);
            if (state == CORE_RD_WAIT) begin
                core_rdata  <= core_oor ? OOR_RDATA : mem_rdata;
                core_rvalid <= 1'b1;
            end
        end
    end
endmodule
